// File: rtl/riscv_mem_pkg.sv
// Shared types and opcode helpers for the load/store engine.
package riscv_mem_pkg;

  typedef enum logic [3:0] {
    OP_LB  = 4'd0,
    OP_LH  = 4'd1,
    OP_LW  = 4'd2,
    OP_LBU = 4'd3,
    OP_LHU = 4'd4,
    OP_LWU = 4'd5,
    OP_SD  = 4'd6,
    OP_SW  = 4'd7,
    OP_SH  = 4'd8,
    OP_SB  = 4'd9,
    OP_LD  = 4'd10
  } mem_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_WAIT,
    S_WR,
    S_RESP
  } mac_state_e;

  typedef struct packed {
    mem_op_e     op;
    logic [63:0] addr;
    logic [63:0] wdata;
  } mem_req_t;

  function automatic logic is_valid_op(input logic [3:0] op);
    return op <= 4'd10;
  endfunction

  function automatic logic is_load(input mem_op_e op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_LWU, OP_LD: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_rmw(input mem_op_e op);
    case (op)
      OP_SW, OP_SH, OP_SB: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] op_size(input mem_op_e op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 4'd1;
      OP_LH, OP_LHU, OP_SH: return 4'd2;
      OP_LW, OP_LWU, OP_SW: return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic misaligned(input mem_op_e op, input logic [2:0] off);
    case (op_size(op))
      4'd2:    return off[0];
      4'd4:    return |off[1:0];
      4'd8:    return |off;
      default: return 1'b0;
    endcase
  endfunction

  // Bytes of the 64-bit word touched by an access of the given size at off.
  function automatic logic [7:0] byte_mask(input logic [3:0] size, input logic [2:0] off);
    logic [7:0] m;
    case (size)
      4'd1:    m = 8'h01;
      4'd2:    m = 8'h03;
      4'd4:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << off;
  endfunction

endpackage

// File: rtl/load_align_extend.sv
// Selects the addressed lane of a read word and sign/zero-extends it.
module load_align_extend
  import riscv_mem_pkg::*;
(
  input  logic [63:0] rdata,
  input  logic [2:0]  off,
  input  mem_op_e     op,
  output logic [63:0] result
);

  logic [63:0] lane;
  assign lane = rdata >> {off, 3'b000};

  always_comb begin
    result = lane;
    case (op)
      OP_LB:   result = {{56{lane[7]}},  lane[7:0]};
      OP_LH:   result = {{48{lane[15]}}, lane[15:0]};
      OP_LW:   result = {{32{lane[31]}}, lane[31:0]};
      OP_LBU:  result = {56'd0, lane[7:0]};
      OP_LHU:  result = {48'd0, lane[15:0]};
      OP_LWU:  result = {32'd0, lane[31:0]};
      default: result = lane;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequential load/store engine: aligned loads, full-word sd, and
// read-modify-write sub-word stores against a memory without byte enables.
module mem_access_ctrl
  import riscv_mem_pkg::*;
#(
  parameter int MEM_RD_LAT = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [63:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata
);

  localparam logic [2:0] LAT3 = 3'(MEM_RD_LAT);

  mac_state_e  state_q, state_d;
  mem_req_t    req_q, req_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [63:0] wword_q, wword_d;
  logic [63:0] res_q, res_d;

  mem_op_e     req_op_e;
  logic [2:0]  off;
  logic [7:0]  bmask;
  logic [63:0] wshift, merged, ext;

  assign req_op_e = mem_op_e'(req_op);
  assign off      = req_q.addr[2:0];

  load_align_extend u_lae (
    .rdata  (mem_rdata),
    .off    (off),
    .op     (req_q.op),
    .result (ext)
  );

  // Sub-word store merge: only the addressed bytes take store data.
  always_comb begin
    bmask  = byte_mask(op_size(req_q.op), off);
    wshift = req_q.wdata << {off, 3'b000};
    merged = '0;
    for (int i = 0; i < 8; i++) begin
      merged[8*i +: 8] = bmask[i] ? wshift[8*i +: 8] : mem_rdata[8*i +: 8];
    end
  end

  assign req_ready  = (state_q == S_IDLE) && reset;
  assign mem_rd     = (state_q == S_RD);
  assign mem_wr     = (state_q == S_WR);
  assign mem_wdata  = wword_q;
  assign mem_addr   = {req_q.addr[63:3], 3'b000};
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = resp_valid ? res_q : 64'd0;
  assign resp_err   = resp_valid && err_q;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    wword_d = wword_q;
    res_d   = res_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          req_d   = '{op: req_op_e, addr: req_addr, wdata: req_wdata};
          res_d   = '0;
          err_d   = 1'b0;
          wword_d = req_wdata;
          if (!is_valid_op(req_op) || misaligned(req_op_e, req_addr[2:0])) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else if (is_load(req_op_e) || is_rmw(req_op_e)) begin
            state_d = S_RD;
          end else begin
            state_d = S_WR;
          end
        end
      end
      S_RD: begin
        cnt_d   = 3'd1;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        // mem_rdata is only trusted in the cycle the counter reaches the latency.
        if (cnt_q == LAT3) begin
          if (is_load(req_q.op)) begin
            res_d   = ext;
            state_d = S_RESP;
          end else begin
            wword_d = merged;
            state_d = S_WR;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_WR:    state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      wword_q <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      wword_q <= wword_d;
      res_q   <= res_d;
    end
  end

endmodule
